// File: rtl/dmem_stage_sync.sv
// dmem_stage_sync: synchronous RV32 data-memory stage with valid/ready request and response
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_instr, req_addr, req_wdata  EX/MEM instruction, ALU result (address or pass-through), store data
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_err              load data / pass-through / 0, error code (01 misaligned, 10 range, 11 illegal)
module dmem_stage_sync #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_instr,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic [1:0]      rsp_err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic {IDLE, RESP} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [XLEN-1:0] word_q, word_d;
    logic [2:0]      f3_q;
    logic [1:0]      lane_q;
    logic [1:0]      err_q, err_d;
    logic            load_q, load_d;

    logic             accept, is_load, is_store, is_mem, illegal, misaligned, oor, we;
    logic [2:0]       f3;
    logic [1:0]       lane;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [XLEN-1:0]  wd;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic             unused_instr;

    assign unused_instr = ^{req_instr[31:15], req_instr[11:7]};

    assign rsp_valid = state_q == RESP;
    assign req_ready = rst_n & (state_q == IDLE | rsp_ready);
    assign accept    = req_valid & req_ready;

    assign f3       = req_instr[14:12];
    assign lane     = req_addr[1:0];
    assign idx      = req_addr[IDX_W+1:2];
    assign is_load  = req_instr[6:0] == OP_LOAD;
    assign is_store = req_instr[6:0] == OP_STORE;
    assign is_mem   = is_load | is_store;

    // Legal loads are 000,001,010,100,101; legal stores are 000,001,010.
    assign illegal    = is_load ? (f3 == 3'b011 || f3[2:1] == 2'b11) : is_store ? (f3 > 3'b010) : 1'b0;
    assign misaligned = (f3[1:0] == 2'b10 && lane != 2'b00) || (f3[1:0] == 2'b01 && lane[0]);
    assign oor        = |req_addr[XLEN-1:IDX_W+2];

    assign err_d  = !is_mem ? 2'b00 : illegal ? 2'b11 : misaligned ? 2'b01 : oor ? 2'b10 : 2'b00;
    assign we     = accept & is_store & (err_d == 2'b00);
    assign load_d = is_load & (err_d == 2'b00);
    assign word_d = load_d ? mem[idx] : is_mem ? '0 : req_addr;

    assign be = f3[1:0] == 2'b00 ? 4'b0001 << lane :
                f3[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wd = f3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
                f3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;

    always_comb begin
        state_d = state_q;
        if (accept)
            state_d = RESP;
        else if (state_q == RESP && rsp_ready)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            err_q   <= 2'b00;
            load_q  <= 1'b0;
            f3_q    <= 3'b000;
            lane_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            if (accept) begin
                word_q <= word_d;
                err_q  <= err_d;
                load_q <= load_d;
                f3_q   <= f3;
                lane_q <= lane;
            end
        end
    end

    // Array is never reset; accept already carries rst_n so nothing is written during reset.
    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem[idx][i*8 +: 8] <= wd[i*8 +: 8];
    end

    // Lane select and extension act on the registered word so the response stays stable while held.
    assign byte_sel = word_q[{lane_q, 3'b000} +: 8];
    assign half_sel = lane_q[1] ? word_q[31:16] : word_q[15:0];

    assign rsp_rdata = !load_q          ? word_q :
                       f3_q == 3'b000   ? {{24{byte_sel[7]}}, byte_sel} :
                       f3_q == 3'b001   ? {{16{half_sel[15]}}, half_sel} :
                       f3_q == 3'b100   ? {24'd0, byte_sel} :
                       f3_q == 3'b101   ? {16'd0, half_sel} : word_q;
    assign rsp_err = err_q;
endmodule

// File: tb/tb_dmem_stage_sync.sv
// tb_dmem_stage_sync: scoreboard bench for dmem_stage_sync with directed vectors
module tb_dmem_stage_sync;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] OP = 7'b0110011;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_instr = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   stalls = 0;

    dmem_stage_sync dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_instr(req_instr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
        return {17'd0, f3, 5'd0, op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Presents a request from posedge+1 and returns at posedge+1 after it is accepted.
    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] w,
                         input logic [31:0] ed, input logic [1:0] ee);
        int  n;
        bit  ok;
        req_valid = 1'b1;
        req_instr = ins;
        req_addr  = a;
        req_wdata = w;
        exp_q.push_back('{d: ed, e: ee});
        n = 0;
        do begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end
        stalls += n - 1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected: got rdata=%h err=%b expected no response", rsp_rdata, rsp_err);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                if (rsp_rdata !== x.d || rsp_err !== x.e) begin
                    failures++;
                    $display("FAIL rsp: got rdata=%h err=%b expected rdata=%h err=%b", rsp_rdata, rsp_err, x.d, x.e);
                end
            end
        end
    end

    initial begin
        #12;
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_err", {30'd0, rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming burst: every request back to back with rsp_ready=1.
        stalls = 0;
        issue(mk(3'b010, ST), 32'h10, 32'hDEADBEEF, 32'h0, 2'b00);
        chk("rsp_valid_t1", {31'd0, rsp_valid}, 32'd1);
        issue(mk(3'b010, LD), 32'h10, 32'h0, 32'hDEADBEEF, 2'b00);
        issue(mk(3'b010, ST), 32'h20, 32'h80017F80, 32'h0, 2'b00);
        issue(mk(3'b000, LD), 32'h20, 32'h0, 32'hFFFFFF80, 2'b00);
        issue(mk(3'b100, LD), 32'h20, 32'h0, 32'h00000080, 2'b00);
        issue(mk(3'b001, LD), 32'h22, 32'h0, 32'hFFFF8001, 2'b00);
        issue(mk(3'b101, LD), 32'h22, 32'h0, 32'h00008001, 2'b00);
        issue(mk(3'b010, ST), 32'h30, 32'h0, 32'h0, 2'b00);
        issue(mk(3'b000, ST), 32'h31, 32'h123456AA, 32'h0, 2'b00);
        issue(mk(3'b010, LD), 32'h30, 32'h0, 32'h0000AA00, 2'b00);
        issue(mk(3'b001, ST), 32'h32, 32'hFFFF1234, 32'h0, 2'b00);
        issue(mk(3'b010, LD), 32'h30, 32'h0, 32'h1234AA00, 2'b00);
        chk("stream_no_stall", stalls, 32'd0);

        // Error paths.
        issue(mk(3'b010, ST), 32'h0, 32'h0BADF00D, 32'h0, 2'b00);
        issue(mk(3'b010, LD), 32'h06, 32'h0, 32'h0, 2'b01);
        issue(mk(3'b010, ST), 32'h1000, 32'hFFFFFFFF, 32'h0, 2'b10);
        issue(mk(3'b010, LD), 32'h0, 32'h0, 32'h0BADF00D, 2'b00);
        issue(mk(3'b011, LD), 32'h0, 32'h0, 32'h0, 2'b11);
        issue(mk(3'b011, LD), 32'h1, 32'h0, 32'h0, 2'b11);
        issue(mk(3'b100, ST), 32'h0, 32'h0, 32'h0, 2'b11);
        issue(mk(3'b001, ST), 32'h33, 32'h5555, 32'h0, 2'b01);
        issue(mk(3'b010, ST), 32'h12, 32'h77777777, 32'h0, 2'b01);
        issue(mk(3'b010, LD), 32'h10, 32'h0, 32'hDEADBEEF, 2'b00);
        issue(mk(3'b010, LD), 32'h30, 32'h0, 32'h1234AA00, 2'b00);
        issue(mk(3'b010, LD), 32'h1002, 32'h0, 32'h0, 2'b01);
        issue(mk(3'b000, OP), 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 2'b00);
        idle(3);

        // Back-pressure: response held for 3 cycles, no new accept.
        rsp_ready = 1'b0;
        issue(mk(3'b010, LD), 32'h20, 32'h0, 32'h80017F80, 2'b00);
        req_valid = 1'b1;
        req_instr = mk(3'b010, ST);
        req_addr  = 32'h20;
        req_wdata = 32'h99999999;
        repeat (3) begin
            @(negedge clk);
            chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_rdata", rsp_rdata, 32'h80017F80);
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        idle(2);
        issue(mk(3'b010, LD), 32'h20, 32'h0, 32'h80017F80, 2'b00);
        idle(3);

        // Reset while a response is held; a store presented during reset is not performed.
        rsp_ready = 1'b0;
        issue(mk(3'b000, OP), 32'h11111111, 32'h0, 32'h11111111, 2'b00);
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_mid_rdata", rsp_rdata, 32'd0);
        req_valid = 1'b1;
        req_instr = mk(3'b010, ST);
        req_addr  = 32'h10;
        req_wdata = 32'h55555555;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b0;
        void'(exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        issue(mk(3'b010, LD), 32'h10, 32'h0, 32'hDEADBEEF, 2'b00);
        issue(mk(3'b000, 7'b0010011), 32'h13572468, 32'h0, 32'h13572468, 2'b00);
        idle(4);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
